// File: rtl/accumulator_control_fsm.sv
// accumulator_control_fsm: multicycle fetch/decode/memory sequencer for the accumulator CPU
package opcodes;
  typedef enum logic [3:0] {
    OP_NOP = 4'd0, OP_JMP = 4'd1, OP_JMPZ = 4'd2, OP_JMPNZ = 4'd3,
    OP_LDA = 4'd4, OP_ADD = 4'd5, OP_SUB = 4'd6, OP_AND = 4'd7,
    OP_OR = 4'd8, OP_NOT = 4'd9, OP_LSL = 4'd10, OP_LSR = 4'd11,
    OP_STA = 4'd15
  } opcode_t;
  typedef enum logic [3:0] {
    FnACC = 4'd0, FnMem = 4'd1, FnADD = 4'd2, FnSUB = 4'd3, FnAND = 4'd4,
    FnOR = 4'd5, FnNOT = 4'd6, FnLSL = 4'd7, FnLSR = 4'd8
  } alu_functions_t;
endpackage

module accumulator_control_fsm
  import opcodes::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Run,
  input  logic [3:0] Opcode,
  input  logic       Zero,
  input  logic       MemAck,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       AddrSel,
  output logic       LoadIR,
  output logic       LoadPC,
  output logic       PCSel,
  output logic       LoadAcc,
  output logic [3:0] AluFn,
  output logic       Retired,
  output logic       IllegalOp
);
  typedef enum logic [1:0] {FETCH, DECODE, MEMRD, MEMWR} state_t;
  state_t state, next;
  opcode_t op;
  alu_functions_t alu_fn;
  logic mem_req, mem_write, addr_sel, load_ir, load_pc, pc_sel, load_acc, retired, illegal;
  assign op = opcode_t'(Opcode);
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) state <= FETCH;
    else state <= next;
  always_comb begin
    next = state;
    {mem_req, mem_write, addr_sel, load_ir, load_pc, pc_sel, load_acc, retired, illegal} = '0;
    alu_fn = FnACC;
    case (state)
      FETCH: if (Run) begin
        mem_req = 1'b1;
        if (MemAck) begin
          load_ir = 1'b1;
          load_pc = 1'b1;
          next = DECODE;
        end
      end
      DECODE: begin
        next = FETCH;
        retired = 1'b1;
        case (op)
          OP_NOP: ;
          OP_JMP: {load_pc, pc_sel} = 2'b11;
          OP_JMPZ: {load_pc, pc_sel} = {2{Zero}};
          OP_JMPNZ: {load_pc, pc_sel} = {2{~Zero}};
          OP_NOT: {alu_fn, load_acc} = {FnNOT, 1'b1};
          OP_LSL: {alu_fn, load_acc} = {FnLSL, 1'b1};
          OP_LSR: {alu_fn, load_acc} = {FnLSR, 1'b1};
          OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR: {next, retired} = {MEMRD, 1'b0};
          OP_STA: {next, retired} = {MEMWR, 1'b0};
          default: illegal = 1'b1;
        endcase
      end
      MEMRD: begin
        mem_req = 1'b1;
        addr_sel = 1'b1;
        alu_fn = op == OP_LDA ? FnMem :
                 op == OP_ADD ? FnADD :
                 op == OP_SUB ? FnSUB :
                 op == OP_AND ? FnAND :
                 op == OP_OR  ? FnOR  : FnACC;
        if (MemAck) {load_acc, retired, next} = {2'b11, FETCH};
      end
      MEMWR: begin
        {mem_req, mem_write, addr_sel} = 3'b111;
        if (MemAck) {retired, next} = {1'b1, FETCH};
      end
    endcase
  end
  // Gate with Reset so an in-flight request drops in the same cycle reset rises.
  assign {MemReq, MemWrite, AddrSel, LoadIR, LoadPC, PCSel, LoadAcc, Retired, IllegalOp} =
    Reset ? 9'b0 : {mem_req, mem_write, addr_sel, load_ir, load_pc, pc_sel, load_acc, retired, illegal};
  assign AluFn = Reset ? FnACC : alu_fn;
endmodule

// File: doc/accumulator_control_fsm.md
# accumulator_control_fsm

Multicycle control sequencer for the 4-bit-opcode accumulator CPU. It decodes the current instruction's opcode from the `opcodes` package and steps through fetch, decode and memory phases. It drives the datapath load enables, memory request handshake, address/PC selects and the `alu_functions_t` code. It sits between the instruction register and the datapath/memory interface, and is the sole consumer of the opcode encoding.

## Interface
Parameters:
- none. The opcode and ALU encodings come from `opcodes::*`.

Ports:
- `Clock`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Run`  in  1  when low, no new instruction fetch starts.
- `Opcode`  in  4  IR[15:12]; valid from the cycle after the fetch acknowledge until the next fetch acknowledge.
- `Zero`  in  1  accumulator == 0 flag.
- `MemAck`  in  1  memory completes the current request this cycle.
- `MemReq`  out  1  memory request.
- `MemWrite`  out  1  1 = write accumulator to memory; qualified by `MemReq`.
- `AddrSel`  out  1  0 = PC, 1 = IR[11:0].
- `LoadIR`  out  1  IR captures memory read data.
- `LoadPC`  out  1  PC update enable.
- `PCSel`  out  1  0 = PC+1, 1 = IR[11:0].
- `LoadAcc`  out  1  accumulator captures the ALU result.
- `AluFn`  out  4  `alu_functions_t`.
- `Retired`  out  1  one-cycle pulse when an instruction completes.
- `IllegalOp`  out  1  one-cycle pulse on decode of an opcode 12, 13 or 14.

## Operation
- States: FETCH, DECODE, MEMRD, MEMWR. Reset state is FETCH.
- Outputs are combinational from state and inputs. While `Reset` is high, all outputs are 0 and `AluFn` = FnACC.
- Default values in every state: all enables 0, `AluFn` = FnACC.

FETCH:
- If `Run` = 1: `MemReq`=1, `AddrSel`=0.
- On `MemAck`: `LoadIR`=1, `LoadPC`=1, `PCSel`=0, and the next state is DECODE.
- Without `MemAck`, or with `Run` = 0: stay in FETCH.

DECODE: always one cycle. Action by opcode:
- NOP: go to FETCH.
- JMP: `LoadPC`=1, `PCSel`=1; go to FETCH.
- JMPZ: if `Zero`, `LoadPC`=1, `PCSel`=1; go to FETCH.
- JMPNZ: if not `Zero`, `LoadPC`=1, `PCSel`=1; go to FETCH.
- NOT / LSL / LSR: `AluFn` = FnNOT / FnLSL / FnLSR, `LoadAcc`=1; go to FETCH.
- LDA, ADD, SUB, AND, OR: go to MEMRD.
- STA: go to MEMWR.
- Opcodes 12–14: `IllegalOp`=1, executed as NOP; go to FETCH.

MEMRD:
- `MemReq`=1, `AddrSel`=1.
- `AluFn` by opcode: LDA→FnMem, ADD→FnADD, SUB→FnSUB, AND→FnAND, OR→FnOR.
- On `MemAck`: `LoadAcc`=1; go to FETCH. Otherwise hold all outputs.

MEMWR:
- `MemReq`=1, `MemWrite`=1, `AddrSel`=1, `AluFn`=FnACC.
- On `MemAck`: go to FETCH.

Retirement:
- `Retired`=1 in exactly the cycle that transitions from DECODE, MEMRD or MEMWR to FETCH.
- Exactly one `Retired` pulse per instruction, including illegal ones.

## Timing
- Minimum cycles per instruction:
  - 2 for NOP, jumps, unary ops and illegal opcodes.
  - 3 for LDA, ADD, SUB, AND, OR, STA.
- Each `MemAck` wait cycle adds one cycle.
- `MemReq` stays asserted, with stable `AddrSel`/`MemWrite`/`AluFn`, from the first request cycle until the `MemAck` cycle inclusive.
- `MemAck` while `MemReq`=0 is ignored.
- `Run` falling mid-instruction does not abort. The instruction completes, then the block idles in FETCH with `MemReq`=0.
- Reset asserted mid-request:
  - `MemReq` drops in the same cycle (asynchronous).
  - The state returns to FETCH; no `Retired` or `IllegalOp` pulse.
- `Zero` is sampled only in DECODE and uses the accumulator value at that cycle.
- No two of `LoadIR`, `LoadAcc` and `MemWrite` are ever asserted together.

## Test plan
- Reset and idle: reset with `Run`=0, then release → all outputs 0, `AluFn`=0, FETCH held, `MemReq`=0 indefinitely.
- ADD with memory waits: `Run`=1, `MemAck` asserted the first cycle, `Opcode`=5, data-phase `MemAck` delayed 2 cycles.
  - `AluFn`=FnADD stable for 3 cycles.
  - `LoadAcc`=1 only in the ack cycle.
  - `Retired` pulse in that cycle; 5 cycles total.
- Conditional jumps: JMPZ (2) with `Zero`=1 → `LoadPC`=1, `PCSel`=1 in DECODE. The same instruction with `Zero`=0 → `LoadPC`=0. JMPNZ (3) gives the mirrored result.
- STA: `Opcode`=15 → MEMWR with `MemReq`=`MemWrite`=`AddrSel`=1, `LoadAcc`=0; `Retired` on ack.
- Illegal and unary opcodes: `Opcode`=13 → `IllegalOp` and `Retired` pulse together in DECODE; no enables. `Opcode`=10 → `AluFn`=FnLSL, `LoadAcc`=1; 2 cycles.
- Reset mid-MEMRD with `MemReq` high → `MemReq` low within the same cycle. After release, a fetch restarts with `AddrSel`=0 and no `Retired` pulse is emitted.
